// File: rtl/mul_job_pkg.sv
// Shared types, widths and helpers for the multiply-job arbiter and its
// shift-add datapath.
package mul_job_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULT  = 2'd1,
    COUNT = 2'd2
  } state_t;

  localparam int AW    = 24;
  localparam int RW    = 32;
  localparam int PW    = 48;
  localparam int LW    = 6;
  localparam int STEPS = AW;

  typedef struct packed {
    logic [RW-1:0] w;
    logic [LW-1:0] l;
    logic          ovf;
  } rsp_t;

  function automatic logic [LW-1:0] popcount32(input logic [RW-1:0] v);
    logic [LW-1:0] c;
    c = '0;
    for (int i = 0; i < RW; i++) c = c + LW'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/mul_shift_add.sv
// Serial 24x24 shift-add multiplier: one multiplier bit per enabled cycle,
// fixed 24 steps, full 48-bit accumulator.
module mul_shift_add
  import mul_job_pkg::*;
(
  input  logic          clk,
  input  logic          n_reset,
  input  logic          load,
  input  logic          step_en,
  input  logic [AW-1:0] a1,
  input  logic [AW-1:0] a2,
  output logic [PW-1:0] acc,
  output logic          last
);

  logic [PW-1:0] mcand;
  logic [AW-1:0] mplier;
  logic [4:0]    step;

  // Multiplicand shifts left and multiplier shifts right each step, which is
  // the same as adding a1 << step when a2[step] is set.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      step   <= '0;
    end else if (load) begin
      mcand  <= PW'(a1);
      mplier <= a2;
      acc    <= '0;
      step   <= '0;
    end else if (step_en) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      step   <= step + 5'd1;
    end
  end

  assign last = (step == 5'(STEPS-1));

endmodule

// File: rtl/mul_job_arbiter.sv
// Round-robin arbiter + sequencer sharing one serial multiply/popcount engine
// between NREQ requesters; fixed 25-cycle grant-to-response latency.
module mul_job_arbiter
  import mul_job_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = 24,
  parameter int RW   = 32
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_a1,
  input  logic [NREQ*AW-1:0]   req_a2,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [RW-1:0]        rsp_w,
  output logic [5:0]           rsp_l,
  output logic                 rsp_ovf,
  output logic                 busy,
  output logic [15:0]          op_count
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t                      state, state_d;
  logic [IDW-1:0]              rr_ptr, id, pick_id;
  logic [NREQ-1:0][AW-1:0]     a1_v, a2_v;
  logic [2*NREQ-1:0]           req_dbl;
  logic [NREQ-1:0]             req_rot;
  int                          pick_ofs, pick_sum;
  logic                        load, step_en, do_grant, do_rsp;
  logic [PW-1:0]               acc;
  logic                        last;
  rsp_t                        rsp_q;

  assign a1_v = req_a1;
  assign a2_v = req_a2;

  // Rotate requests so rr_ptr sits at bit 0; lowest set bit is the winner.
  assign req_dbl = {req, req} >> rr_ptr;
  assign req_rot = req_dbl[NREQ-1:0];

  always_comb begin
    pick_ofs = 0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (req_rot[k]) pick_ofs = k;
    end
    pick_sum = int'(rr_ptr) + pick_ofs;
    if (pick_sum >= NREQ) pick_sum = pick_sum - NREQ;
    pick_id = IDW'(pick_sum);
  end

  always_ff @(posedge clk) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d  = state;
    load     = 1'b0;
    step_en  = 1'b0;
    do_grant = 1'b0;
    do_rsp   = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          do_grant = 1'b1;
          load     = 1'b1;
          state_d  = MULT;
        end
      end
      MULT: begin
        step_en = 1'b1;
        if (last) state_d = COUNT;
      end
      COUNT: begin
        do_rsp  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  mul_shift_add u_dp (
    .clk     (clk),
    .n_reset (n_reset),
    .load    (load),
    .step_en (step_en),
    .a1      (a1_v[pick_id]),
    .a2      (a2_v[pick_id]),
    .acc     (acc),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_q     <= '0;
      op_count  <= '0;
      rr_ptr    <= '0;
      id        <= '0;
    end else begin
      gnt       <= do_grant ? (NREQ'(1) << pick_id) : '0;
      rsp_valid <= do_rsp   ? (NREQ'(1) << id)      : '0;
      if (do_grant) begin
        id     <= pick_id;
        rr_ptr <= (pick_id == IDW'(NREQ-1)) ? '0 : pick_id + 1'b1;
      end
      if (do_rsp) begin
        rsp_q.w   <= acc[RW-1:0];
        rsp_q.l   <= popcount32(acc[RW-1:0]);
        rsp_q.ovf <= |acc[PW-1:RW];
        op_count  <= op_count + 16'd1;
      end
    end
  end

  assign rsp_w   = rsp_q.w;
  assign rsp_l   = rsp_q.l;
  assign rsp_ovf = rsp_q.ovf;
  assign busy    = (state != IDLE);

endmodule

// File: doc/mul_job_arbiter.md
Name: mul_job_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 24x24 shift-add multiply and popcount datapath between NREQ requesters.
- Each accepted job returns three things to its requester: the low 32 product bits (W), the count of ones in W (L), and an overflow flag.
- Sits between the bus-facing register blocks and the shared arithmetic datapath.
- Replaces per-requester single-shot multiply logic with one deterministic, fixed-latency engine.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 24, operand width.
- RW, 32, result width returned to the requester.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- n_reset  in  1  synchronous active-low reset.
- req  in  NREQ  per-requester job request, level.
- req_a1  in  NREQ*AW  packed first operands; slice i belongs to requester i.
- req_a2  in  NREQ*AW  packed second operands.
- gnt  out  NREQ  one-hot, one-cycle acceptance pulse.
- rsp_valid  out  NREQ  one-hot, one-cycle response pulse to the job owner.
- rsp_w  out  RW  product bits [31:0].
- rsp_l  out  6  popcount of rsp_w (0..32).
- rsp_ovf  out  1  set when product bits [47:32] are nonzero.
- busy  out  1  high whenever state is not IDLE.
- op_count  out  16  count of completed jobs, wraps.

Behaviour:
- Reset:
  - Sampled only on clk when n_reset=0.
  - gnt=0, rsp_valid=0, rsp_w=0, rsp_l=0, rsp_ovf=0, busy=0, op_count=0.
  - rr_ptr=0, state=IDLE.
- States: IDLE, MULT, COUNT.
- IDLE, with any req bit high at edge E0:
  - Pick the first set bit at or after rr_ptr, wrapping.
  - Set gnt[id]=1 for one cycle.
  - Latch a1, a2 and id; clear the accumulator; step=0.
  - rr_ptr <= (id+1) mod NREQ; go to MULT.
- IDLE, with no req: stay, no outputs change.
- MULT, one bit per edge:
  - If a2[step]=1, acc += a1 << step, with acc 48 bits wide and no truncation.
  - step increments. After step 23 (edge E24), go to COUNT.
  - The step count is fixed at 24 regardless of operand values; there is no early exit.
- COUNT (edge E25):
  - rsp_w <= acc[31:0].
  - rsp_l <= popcount(acc[31:0]).
  - rsp_ovf <= |acc[47:32].
  - rsp_valid[id]=1 for one cycle.
  - op_count += 1, wrapping 0xFFFF->0x0000.
  - Go to IDLE.
- Latency and throughput:
  - gnt pulse to rsp_valid pulse is exactly 25 cycles.
  - The earliest next gnt is at E26, i.e. 26 cycles between consecutive grants.
- Output hold: rsp_w, rsp_l and rsp_ovf hold their values until the next COUNT edge.
- Handshake rules:
  - A requester holds req and its operands stable until it sees gnt.
  - The requester drops req on the cycle after gnt, or keeps it high to queue another job.
  - A req dropped before grant is forgotten; nothing is stored.
  - Operand changes after gnt have no effect on the in-flight job.
  - req bits are ignored outside IDLE; no queueing is done inside the block.
- Fairness: a requester that holds req is granted within NREQ jobs.
- Simultaneous events:
  - A new req in the COUNT cycle is not granted until the IDLE edge E26.
  - Response and grant never share a cycle.
- Reset mid-operation:
  - Aborts the job; no rsp_valid is issued and op_count does not increment.
  - State returns to IDLE and rr_ptr returns to 0.
- Zero operand (a1=0 or a2=0): W=0, L=0, ovf=0, with the full 25-cycle latency.

Decomposition:
- Package mul_job_pkg holds:
  - State enum {IDLE, MULT, COUNT}.
  - Constants AW=24, RW=32, PW=48 (product width), LW=6.
  - Function popcount32.
- Sub-module mul_shift_add holds the datapath registers:
  - Inputs: a1/a2 load, step enable.
  - Outputs: 48-bit accumulator, last-step flag.
- The top level keeps the arbiter, FSM, response registers and op_count.

Test Plan:
- Single job: req[0], a1=3, a2=5.
  - gnt[0] pulses once.
  - 25 cycles later rsp_valid[0] pulses with rsp_w=0x0000000F, rsp_l=4, rsp_ovf=0, op_count=1.
- Overflow: a1=a2=0xFFFFFF.
  - Product is 0xFFFFFE000001.
  - Response is rsp_w=0xFE000001, rsp_l=8, rsp_ovf=1.
- Round-robin, NREQ=2, both req held continuously from reset:
  - Grant order is 0,1,0,1.
  - Grants are spaced exactly 26 cycles apart.
  - Each rsp_valid goes to the matching owner bit.
- Reset mid-operation:
  - Sequence: job a1=7, a2=9; assert n_reset=0 for one cycle at gnt+10.
  - No rsp_valid appears; busy=0 and op_count=0 after reset.
  - A fresh job with a1=2, a2=2 returns rsp_w=4, rsp_l=1.
- Zero and operand stability:
  - Job a1=0x123456, a2=0; change req_a1 and req_a2 right after gnt.
  - Response is rsp_w=0, rsp_l=0, rsp_ovf=0 at the fixed 25-cycle latency.
- Counter wrap:
  - Force or run op_count to 0xFFFF; one more job sets op_count=0x0000.
  - Request dropped one cycle before an IDLE grant opportunity: no gnt is issued.
